// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the execute-stage divider.
//   - div_state_t      : divider FSM state codes (IDLE / RUN / DONE)
//   - DIV_CONTROL,
//     DIVU_CONTROL     : 5-bit alucontrol codes taken from unused encodings
//   - is_div_op,
//     is_signed_div    : decoder helpers that derive start / signed_div
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [4:0] DIV_CONTROL  = 5'b11100;
  localparam logic [4:0] DIVU_CONTROL = 5'b11101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // The decoder raises start for either flavour of divide.
  function automatic logic is_div_op(input logic [4:0] alucontrol);
    return (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] alucontrol);
    return alucontrol == DIV_CONTROL;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider handshake.
//   master (pipeline side): drives start, signed_div, annul, a, b;
//                           receives stall, ready, hi, lo.
//   slave  (div_unit)     : the mirror image.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_div, annul, a, b,
    input  stall, ready, hi, lo
  );

  modport slave (
    input  start, signed_div, annul, a, b,
    output stall, ready, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS DIV/DIVU.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : div_unit_if.slave
//     start/signed_div/a/b : request from EX (a = dividend, b = divisor)
//     annul                : flush; aborts any division, highest priority
//     stall                : combinational pipeline freeze
//     ready                : one-cycle pulse, hi/lo valid for the HI/LO write
//     hi/lo                : remainder / quotient, registered
// One quotient bit per cycle on magnitudes; signs are restored when the
// result is registered. b == 0 bypasses the iteration entirely.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  div_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] pr_q;       // {partial remainder, quotient}
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic               neg_q_q;
  logic               neg_r_q;
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic load, step;

  // Operand magnitudes and result signs, valid in the accepting cycle.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign a_neg  = bus.signed_div & bus.a[WIDTH-1];
  assign b_neg  = bus.signed_div & bus.b[WIDTH-1];
  assign b_zero = (bus.b == '0);
  assign mag_a  = a_neg ? -bus.a : bus.a;
  assign mag_b  = b_neg ? -bus.b : bus.b;

  // Restoring step. The remainder is widened by the bit shifted out of
  // the top so the compare never loses a carry.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh, rem_sub, step_rem, step_quo;
  logic             fits;

  assign rem_sh   = pr_q[2*WIDTH-1:WIDTH-1];
  assign quo_sh   = {pr_q[WIDTH-2:0], 1'b0};
  assign fits     = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub  = rem_sh[WIDTH-1:0] - dvs_q;  // exact whenever fits
  assign step_rem = fits ? rem_sub : rem_sh[WIDTH-1:0];
  assign step_quo = {quo_sh[WIDTH-1:1], fits};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next state and outputs.
  always_comb begin
    // NOTE: every output gets a default first; a path that skipped an
    // assignment would otherwise infer a latch.
    state_d   = state_q;
    bus.stall = 1'b0;
    bus.ready = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          bus.stall = 1'b1;
          load      = 1'b1;
          state_d   = b_zero ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        bus.stall = 1'b1;
        step      = 1'b1;
        if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        // start here still belongs to the retiring instruction.
        bus.ready = 1'b1;
        state_d   = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (bus.annul) begin
      state_d   = DIV_IDLE;
      bus.stall = 1'b0;
      bus.ready = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q    <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (load) begin
        pr_q    <= {{WIDTH{1'b0}}, mag_a};
        dvs_q   <= mag_b;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        cnt_q   <= '0;
        if (b_zero) begin
          hi_q <= bus.a;
          lo_q <= '1;
        end
      end
      if (step) begin
        pr_q  <= {step_rem, step_quo};
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          hi_q <= neg_r_q ? -step_rem : step_rem;
          lo_q <= neg_q_q ? -step_quo : step_quo;
        end
      end
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scenario tasks for div_unit, checked against an arithmetic
// reference model (64-bit integer divide, truncating toward zero).
module tb_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] last_hi, last_lo;   // expected HI/LO after the last completed divide

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // MIPS semantics: quotient truncates toward zero, remainder takes the
  // dividend's sign; divide by zero gives hi = a, lo = all ones.
  function automatic void ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic sv, output logic [W-1:0] q,
                                  output logic [W-1:0] r);
    longint na, nb;
    if (bv == 0) begin
      q = '1;
      r = av;
    end else begin
      if (sv) begin
        na = $signed(av);
        nb = $signed(bv);
      end else begin
        na = {32'h0, av};
        nb = {32'h0, bv};
      end
      q = 32'(na / nb);
      r = 32'(na % nb);
    end
  endfunction

  // Issue one division starting now (just after a rising edge, unit idle)
  // and follow it to ready, checking stall trace, latency and result.
  task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input string name, output int ready_cyc);
    logic [W-1:0] eq, er, got_hi, got_lo;
    int exp_lat, ready_at;
    bit stall_ok;
    ref_div(av, bv, sv, eq, er);
    exp_lat  = (bv == 0) ? 1 : W + 1;
    ready_at = -1;
    stall_ok = 1'b1;
    got_hi   = 'x;
    got_lo   = 'x;
    ready_cyc = -1;
    bus.a = av; bus.b = bv; bus.signed_div = sv; bus.start = 1'b1;
    for (int c = 0; c < W + 8 && ready_at < 0; c++) begin
      @(negedge clk);
      if (bus.stall !== (c < exp_lat)) stall_ok = 1'b0;
      if (bus.ready === 1'b1) begin
        ready_at  = c;
        ready_cyc = cyc;
        got_hi    = bus.hi;
        got_lo    = bus.lo;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    total_cnt++;
    if (ready_at !== exp_lat)
      $display("FAIL %s latency: got %0d expected %0d", name, ready_at, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (!stall_ok)
      $display("FAIL %s stall: got wrong stall pattern expected high for cycles 0..%0d", name, exp_lat - 1);
    else pass_cnt++;
    total_cnt++;
    if (got_lo !== eq)
      $display("FAIL %s lo: got %h expected %h", name, got_lo, eq);
    else pass_cnt++;
    total_cnt++;
    if (got_hi !== er)
      $display("FAIL %s hi: got %h expected %h", name, got_hi, er);
    else pass_cnt++;
    last_hi = er;
    last_lo = eq;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.a = '0; bus.b = '0;
    rst = 1'b1;
    #3;
    total_cnt++;
    if ({bus.stall, bus.ready, bus.hi, bus.lo} !== '0)
      $display("FAIL reset outputs: got stall=%b ready=%b hi=%h lo=%h expected all 0",
               bus.stall, bus.ready, bus.hi, bus.lo);
    else pass_cnt++;
    bus.start = 1'b1;
    #1;
    total_cnt++;
    if (bus.stall !== 1'b1)
      $display("FAIL reset stall with start: got %b expected 1", bus.stall);
    else pass_cnt++;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    last_hi = '0;
    last_lo = '0;
  endtask

  task automatic test_directed();
    int rc;
    run_div(32'd100,       32'd7,         1'b0, "divu_100_7",     rc);
    run_div(32'hFFFF_FFF9, 32'd2,         1'b1, "div_m7_2",       rc);
    run_div(32'd7,         32'hFFFF_FFFE, 1'b1, "div_7_m2",       rc);
    run_div(32'hFFFF_FFFF, 32'd1,         1'b0, "divu_max_1",     rc);
    run_div(32'hFFFF_FFF9, 32'd2,         1'b0, "divu_big_2",     rc);
  endtask

  task automatic test_overflow();
    int rc;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1",     rc);
    run_div(32'h8000_0000, 32'd1,         1'b1, "div_min_1",      rc);
  endtask

  task automatic test_div_by_zero();
    int rc;
    run_div(32'd5,         32'd0, 1'b1, "div_5_0",  rc);
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "div_neg_0", rc);
  endtask

  task automatic test_annul();
    bit stall_ok, ready_seen;
    int rc;
    stall_ok = 1'b1;
    ready_seen = 1'b0;
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!stall_ok) $display("FAIL annul pre-stall: got stall low expected high in cycles 0..9");
    else pass_cnt++;
    bus.annul = 1'b1;        // start still held: annul must win
    @(negedge clk);
    total_cnt++;
    if (bus.stall !== 1'b0 || bus.ready !== 1'b0)
      $display("FAIL annul cycle: got stall=%b ready=%b expected 0 0", bus.stall, bus.ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.stall !== 1'b0)
      $display("FAIL annul idle: got stall=%b expected 0", bus.stall);
    else pass_cnt++;
    for (int c = 0; c < W + 8; c++) begin
      if (bus.ready === 1'b1) ready_seen = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    total_cnt++;
    if (ready_seen) $display("FAIL annul ready: got ready pulse expected none");
    else pass_cnt++;
    total_cnt++;
    if (bus.hi !== last_hi || bus.lo !== last_lo)
      $display("FAIL annul hold: got hi=%h lo=%h expected hi=%h lo=%h",
               bus.hi, bus.lo, last_hi, last_lo);
    else pass_cnt++;
    run_div(32'd9, 32'd3, 1'b0, "divu_9_3_after_annul", rc);
  endtask

  task automatic test_async_reset();
    int rc;
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    total_cnt++;
    if (bus.stall !== 1'b1)
      $display("FAIL mid-run stall: got %b expected 1", bus.stall);
    else pass_cnt++;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    total_cnt++;
    if ({bus.stall, bus.ready, bus.hi, bus.lo} !== '0)
      $display("FAIL async reset outputs: got stall=%b ready=%b hi=%h lo=%h expected all 0",
               bus.stall, bus.ready, bus.hi, bus.lo);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(32'd50, 32'd5, 1'b0, "divu_50_5_after_reset", rc);
  endtask

  task automatic test_back_to_back();
    int r1, r2;
    run_div(32'd10, 32'd3, 1'b0, "b2b_first",  r1);
    run_div(32'd20, 32'd6, 1'b0, "b2b_second", r2);
    total_cnt++;
    if (r2 - r1 !== 34)
      $display("FAIL b2b spacing: got %0d expected 34", r2 - r1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] corners [5];
    logic [W-1:0] av, bv;
    logic sv;
    int rc;
    corners[0] = 32'h0;         corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 24; i++) begin
      sv = 1'($urandom_range(0, 1));
      av = $urandom;
      case ($urandom_range(0, 3))
        0:       bv = $urandom;
        1:       bv = $urandom_range(1, 15);
        2:       bv = '0;
        default: begin
          av = corners[$urandom_range(0, 4)];
          bv = corners[$urandom_range(0, 4)];
        end
      endcase
      run_div(av, bv, sv, $sformatf("rand%0d_%s_%h_%h", i, sv ? "div" : "divu", av, bv), rc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_div_by_zero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
